// File: rtl/tl45_pkg.sv
// tl45_pkg: shared types and constants for the TL45 multiply/divide sequencer
//   muldiv_op_t    : request opcode (MUL low word, DIVU, REMU, reserved)
//   muldiv_state_t : sequencer FSM state
package tl45_pkg;
  localparam int TL45_XLEN = 32;
  localparam logic [31:0] DIV0_QUOT = 32'hFFFFFFFF;
  typedef enum logic [1:0] {MUL = 2'd0, DIVU = 2'd1, REMU = 2'd2, RSVD = 2'd3} muldiv_op_t;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} muldiv_state_t;
endpackage

// File: rtl/tl45_muldiv_dp.sv
// tl45_muldiv_dp: shift-add multiply / restoring divide datapath, one step per cycle
//   i_clk, i_reset_n : clock, async active-low reset
//   load             : capture operands a, b and clear the accumulator
//   step             : perform one iteration for op
//   op               : operation selecting step kind and result source
//   a, b             : operands (multiplicand/multiplier or dividend/divisor)
//   result           : value the registers hold after this cycle's load/step
module tl45_muldiv_dp
  import tl45_pkg::*;
#(
  parameter int XLEN = TL45_XLEN
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            load,
  input  logic            step,
  input  muldiv_op_t      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result
);
  // acc: product accumulator (MUL) or partial remainder (DIVU/REMU)
  // a:   shifted multiplicand (MUL) or dividend shifting out / quotient shifting in
  // b:   shifted multiplier (MUL) or fixed divisor
  logic [XLEN-1:0] acc_q, acc_d, a_q, a_d, b_q, b_d;
  logic [XLEN:0]   trial;
  logic            ge;
  always_comb begin
    trial = {acc_q, a_q[XLEN-1]};
    ge    = trial >= {1'b0, b_q};
    acc_d = load ? '0 : !step ? acc_q :
            op == MUL ? acc_q + (b_q[0] ? a_q : '0) :
            ge ? XLEN'(trial - {1'b0, b_q}) : trial[XLEN-1:0];
    a_d   = load ? a : !step ? a_q :
            op == MUL ? a_q << 1 : {a_q[XLEN-2:0], ge};
    b_d   = load ? b : !step ? b_q : op == MUL ? b_q >> 1 : b_q;
    // Exposing the next-state value lets the top register the result on the final step
    result = op == DIVU ? a_d : acc_d;
  end
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      acc_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      acc_q <= acc_d;
      a_q   <= a_d;
      b_q   <= b_d;
    end
endmodule

// File: rtl/tl45_muldiv_seq.sv
// tl45_muldiv_seq: iterative MUL/DIVU/REMU sequencer with pipeline stall and one-cycle result
//   i_clk, i_reset_n : clock, async active-low reset
//   i_flush          : abandon any operation in progress
//   i_start          : request valid, operands held stable while o_stall is high
//   i_op, i_dr       : opcode and destination register
//   i_a, i_b         : operands
//   o_stall          : stall earlier stages (combinational)
//   o_done, o_dr, o_result : registered one-cycle result, zero otherwise
module tl45_muldiv_seq
  import tl45_pkg::*;
#(
  parameter int XLEN = TL45_XLEN
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_flush,
  input  logic            i_start,
  input  logic [1:0]      i_op,
  input  logic [3:0]      i_dr,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_stall,
  output logic            o_done,
  output logic [3:0]      o_dr,
  output logic [XLEN-1:0] o_result
);
  localparam int CW = $clog2(XLEN);
  muldiv_state_t   state_q, state_d;
  muldiv_op_t      op_q, op_d, op_in;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      dr_q, dr_d, odr_q, odr_d;
  logic [XLEN-1:0] res_q, res_d, dp_result;
  logic            done_q, done_d, accept, quick, step, last;
  tl45_muldiv_dp #(.XLEN(XLEN)) u_dp (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .load      (accept),
    .step      (step),
    .op        (accept ? op_in : op_q),
    .a         (i_a),
    .b         (i_b),
    .result    (dp_result)
  );
  always_comb begin
    op_in   = muldiv_op_t'(i_op);
    accept  = state_q == IDLE && i_start && !i_flush;
    // Reserved op and divide by zero skip the iteration entirely
    quick   = accept && (op_in == RSVD || (op_in != MUL && i_b == '0));
    step    = state_q == BUSY && !i_flush;
    last    = step && cnt_q == CW'(XLEN - 1);
    state_d = i_flush ? IDLE :
              state_q == IDLE ? (accept ? (quick ? DONE : BUSY) : IDLE) :
              state_q == BUSY ? (last ? DONE : BUSY) : IDLE;
    cnt_d   = step ? cnt_q + 1'b1 : '0;
    op_d    = accept ? op_in : op_q;
    dr_d    = accept ? i_dr : dr_q;
    done_d  = quick || last;
    odr_d   = quick ? i_dr : last ? dr_q : '0;
    res_d   = quick ? (op_in == RSVD ? '0 : op_in == DIVU ? XLEN'(DIV0_QUOT) : i_a) :
              last ? dp_result : '0;
    o_stall = i_start && state_q != DONE;
  end
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      state_q <= IDLE;
      op_q    <= MUL;
      cnt_q   <= '0;
      dr_q    <= '0;
      done_q  <= 1'b0;
      odr_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      dr_q    <= dr_d;
      done_q  <= done_d;
      odr_q   <= odr_d;
      res_q   <= res_d;
    end
  assign o_done   = done_q;
  assign o_dr     = odr_q;
  assign o_result = res_q;
endmodule
